// File: rtl/board_pkg.sv
// ---------------------------------------------------------------------------
// board_pkg
// Shared types for the N x N game-board store and its address decoder.
//   cell_e      : 2-bit cell code (EMPTY 00, RSVD 01, P2 10, P1 11)
//   wr_err_e    : write status returned alongside wr_done
//   ctl_state_e : controller state (RUN accepts writes, CLEAR sweeps cells)
//   is_player() : true for the two codes that may be written to a cell
// ---------------------------------------------------------------------------
package board_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        RSVD  = 2'b01,
        P2    = 2'b10,
        P1    = 2'b11
    } cell_e;

    typedef enum logic [1:0] {
        OK       = 2'b00,
        BADADDR  = 2'b01,
        OCCUPIED = 2'b10,
        BADSTATE = 2'b11
    } wr_err_e;

    typedef enum logic {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } ctl_state_e;

    // Both player codes have the MSB set; EMPTY and RSVD do not.
    function automatic logic is_player(input logic [1:0] code);
        return code[1];
    endfunction

endpackage

// File: rtl/board_addr_dec.sv
// ---------------------------------------------------------------------------
// board_addr_dec
// Linear cell index to one-hot write enable for an N x N board.
// Ports:
//   addr_i   [ADDR_W-1:0]  row-major cell index, 0 = upper-left
//   onehot_o [N*N-1:0]     one bit per cell; all zero when addr_i >= N*N
// ---------------------------------------------------------------------------
module board_addr_dec
    import board_pkg::*;
#(
    parameter int N      = 3,
    parameter int ADDR_W = 4
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [N*N-1:0]    onehot_o
);

    // Indices past the last cell match no comparator, so the vector is
    // naturally all zero for out-of-range addresses.
    generate
        for (genvar gi = 0; gi < N*N; gi++) begin : g_dec
            assign onehot_o[gi] = (addr_i == ADDR_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/board_mem_ctl.sv
// ---------------------------------------------------------------------------
// board_mem_ctl
// Parametrised N x N game-board store with a valid/ready write port,
// per-write status, move counter, full flag and a sequenced clear sweep.
// Optional feature macro: BOARD_UNDO_EN (adds undo_req and a one-entry
// last-move register).
// Ports:
//   ph1        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   clr_req    in   start clear sweep (sampled in RUN)
//   undo_req   in   undo last successful move (BOARD_UNDO_EN only)
//   wr_valid   in   write request
//   wr_ready   out  write can be accepted this cycle
//   wr_addr    in   linear cell index, row-major
//   wr_state   in   cell code to write
//   wr_done    out  one-cycle pulse after an accepted write
//   wr_err     out  status qualified by wr_done
//   rd_addr    in   random read index
//   rd_state   out  cell code at rd_addr, 00 when out of range
//   game_board out  packed board, cell i at [2i+1:2i], bits swapped
//   move_cnt   out  number of occupied cells
//   board_full out  move_cnt == N*N
//   busy       out  clear sweep in progress
// ---------------------------------------------------------------------------
module board_mem_ctl
    import board_pkg::*;
#(
    parameter int N      = 3,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 4
) (
    input  logic                ph1,
    input  logic                reset,
    input  logic                clr_req,
`ifdef BOARD_UNDO_EN
    input  logic                undo_req,
`endif
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [1:0]          wr_state,
    output logic                wr_done,
    output logic [1:0]          wr_err,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [1:0]          rd_state,
    output logic [2*N*N-1:0]    game_board,
    output logic [CNT_W-1:0]    move_cnt,
    output logic                board_full,
    output logic                busy
);

    localparam int                CELLS    = N*N;
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(CELLS);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(CELLS-1);

    ctl_state_e          state_q;
    logic [ADDR_W-1:0]   sweep_ptr_q;
    logic [CNT_W-1:0]    move_cnt_q;
    logic                wr_done_q;
    logic [1:0]          wr_err_q;
    logic [1:0]          cells_q [CELLS];
    logic [1:0]          cells_d [CELLS];

    logic [CELLS-1:0]    wr_onehot;
    logic [CELLS-1:0]    undo_mask;
    logic [1:0]          cur_cell;
    logic                addr_ok;
    logic                undo_hold;
    logic                undo_fire;
    logic                accept;
    logic                wr_ok;
    wr_err_e             err_d;

    board_addr_dec #(
        .N      (N),
        .ADDR_W (ADDR_W)
    ) u_dec (
        .addr_i   (wr_addr),
        .onehot_o (wr_onehot)
    );

    assign addr_ok = |wr_onehot;

    // ---------------------------------------------------------------------
    // Optional undo: one-entry record of the last successful write.
    // ---------------------------------------------------------------------
`ifdef BOARD_UNDO_EN
    logic [ADDR_W-1:0] last_addr_q;
    logic              last_vld_q;

    // undo_req blocks writes in RUN even when there is nothing to undo;
    // clr_req still wins over an undo in the same cycle.
    assign undo_hold = (state_q == RUN) && undo_req;
    assign undo_fire = undo_hold && last_vld_q && !clr_req;

    generate
        for (genvar gi = 0; gi < CELLS; gi++) begin : g_undo
            assign undo_mask[gi] = (last_addr_q == ADDR_W'(gi));
        end
    endgenerate
`else
    assign undo_hold = 1'b0;
    assign undo_fire = 1'b0;
    assign undo_mask = '0;
`endif

    assign wr_ready = (state_q == RUN) && !clr_req && !undo_hold;
    assign accept   = wr_valid && wr_ready;

    // Current contents of the addressed cell (EMPTY when out of range).
    always_comb begin
        cur_cell = EMPTY;
        for (int i = 0; i < CELLS; i++) begin
            if (wr_onehot[i]) begin
                cur_cell = cells_q[i];
            end
        end
    end

    // Status priority: address, then cell code, then occupancy.
    always_comb begin
        err_d = OK;
        if (!addr_ok) begin
            err_d = BADADDR;
        end else if (!is_player(wr_state)) begin
            err_d = BADSTATE;
        end else if (cur_cell != EMPTY) begin
            err_d = OCCUPIED;
        end
    end

    assign wr_ok = accept && (err_d == OK);

    // Next-state of every cell: sweep clear, undo clear, or a good write.
    always_comb begin
        for (int i = 0; i < CELLS; i++) begin
            cells_d[i] = cells_q[i];
            if ((state_q == CLEAR) && (sweep_ptr_q == ADDR_W'(i))) begin
                cells_d[i] = EMPTY;
            end else if (undo_fire && undo_mask[i]) begin
                cells_d[i] = EMPTY;
            end else if (wr_ok && wr_onehot[i]) begin
                cells_d[i] = wr_state;
            end
        end
    end

    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CELLS; i++) begin
                cells_q[i] <= EMPTY;
            end
        end else begin
            cells_q <= cells_d;
        end
    end

    // ---------------------------------------------------------------------
    // Control FSM with registered status and counter.
    // ---------------------------------------------------------------------
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            sweep_ptr_q <= '0;
            move_cnt_q  <= '0;
            wr_done_q   <= 1'b0;
            wr_err_q    <= OK;
`ifdef BOARD_UNDO_EN
            last_addr_q <= '0;
            last_vld_q  <= 1'b0;
`endif
        end else begin
            wr_done_q <= accept;
            wr_err_q  <= accept ? err_d : OK;
            case (state_q)
                RUN: begin
                    if (clr_req) begin
                        state_q     <= CLEAR;
                        sweep_ptr_q <= '0;
`ifdef BOARD_UNDO_EN
                        last_vld_q  <= 1'b0;
`endif
                    end else if (undo_fire) begin
                        move_cnt_q  <= move_cnt_q - CNT_W'(1);
`ifdef BOARD_UNDO_EN
                        last_vld_q  <= 1'b0;
`endif
                    end else if (wr_ok) begin
                        if (move_cnt_q != CNT_FULL) begin
                            move_cnt_q <= move_cnt_q + CNT_W'(1);
                        end
`ifdef BOARD_UNDO_EN
                        last_addr_q <= wr_addr;
                        last_vld_q  <= 1'b1;
`endif
                    end else if (accept) begin
`ifdef BOARD_UNDO_EN
                        last_vld_q  <= 1'b0;
`endif
                    end
                end
                CLEAR: begin
                    // clr_req is not looked at here, so holding it cannot
                    // restart the sweep.
                    if (sweep_ptr_q == LAST_IDX) begin
                        state_q     <= RUN;
                        sweep_ptr_q <= '0;
                        move_cnt_q  <= '0;
                    end else begin
                        sweep_ptr_q <= sweep_ptr_q + ADDR_W'(1);
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    // The win checker expects each cell's two code bits swapped.
    generate
        for (genvar gi = 0; gi < CELLS; gi++) begin : g_board
            assign game_board[2*gi]   = cells_q[gi][1];
            assign game_board[2*gi+1] = cells_q[gi][0];
        end
    endgenerate

    always_comb begin
        rd_state = EMPTY;
        for (int i = 0; i < CELLS; i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                rd_state = cells_q[i];
            end
        end
    end

    assign wr_done    = wr_done_q;
    assign wr_err     = wr_err_q;
    assign move_cnt   = move_cnt_q;
    assign board_full = (move_cnt_q == CNT_FULL);
    assign busy       = (state_q == CLEAR);

endmodule
